seg7_scan_n: RTL and testbench

SEG7_SCAN_N -- requirements
Module: seg7_scan_n

---
 rtl/seg7_scan_n.sv | 204 ++++++++++++++++++++
 tb/tb_seg7_scan_n.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_n.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_n
// Description : Multiplexed N-digit seven-segment driver with leading-zero
//               blanking, hex/decimal glyphs, decimal points and PWM anode
//               brightness. All display inputs are sampled once per frame
//               into shadow registers so a frame is always self-consistent.
// Ports       : clk, rst (async, active-high)
//               i_digits_in  [4*DIGITS-1:0]  nibble per digit, digit 0 = LSD
//               i_dp_in      [DIGITS-1:0]    decimal point request per digit
//               i_blank_lz                   leading-zero blanking enable
//               i_hex_mode                   1 = show 10..15 as A b C d E F
//               i_brightness [PWM_BITS-1:0]  anode duty select
//               o_seg_n      [6:0]           segments a..g, active-low
//               o_dp_n                       decimal point, active-low
//               o_dig_n      [DIGITS-1:0]    digit anodes, active-low
//               o_frame_sync                 one-cycle pulse after capture
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_n #(
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 27000,
  parameter int PWM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   i_digits_in,
  input  logic [DIGITS-1:0]     i_dp_in,
  input  logic                  i_blank_lz,
  input  logic                  i_hex_mode,
  input  logic [PWM_BITS-1:0]   i_brightness,
  output logic [6:0]            o_seg_n,
  output logic                  o_dp_n,
  output logic [DIGITS-1:0]     o_dig_n,
  output logic                  o_frame_sync
);

  localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_STEP  = SCAN_DIV / (2 ** PWM_BITS);
  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_DIV - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

  // Scan timing state
  logic [c_PRE_W-1:0]   r_pre;
  logic [c_IDX_W-1:0]   r_idx;

  // Per-frame shadow copies of the display inputs
  logic [4*DIGITS-1:0]  r_sh_digits;
  logic [DIGITS-1:0]    r_sh_dp;
  logic                 r_sh_blank_lz;
  logic                 r_sh_hex;
  logic [PWM_BITS-1:0]  r_sh_bright;

  logic                 w_slot_end;
  logic                 w_frame_end;
  logic [31:0]          w_thresh;
  logic                 w_pwm_en;
  logic [DIGITS-1:0]    w_lz_blank;
  logic [3:0]           w_nib;
  logic                 w_cur_dp;
  logic                 w_cur_blank;
  logic                 w_on;
  logic [6:0]           w_glyph;
  logic [6:0]           w_seg_n_nxt;
  logic                 w_dp_n_nxt;
  logic [DIGITS-1:0]    w_dig_n_nxt;

  assign w_slot_end  = (r_pre == c_PRE_LAST);
  assign w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);

  // --------------------------------------------------------------------------
  // Prescaler and slot index
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else begin
      if (w_slot_end) begin
        r_pre <= '0;
        // With a single digit the index stays at zero and every slot end
        // is also a frame boundary.
        r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
      end else begin
        r_pre <= r_pre + c_PRE_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Shadow capture at the frame boundary
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_digits   <= '0;
      r_sh_dp       <= '0;
      r_sh_blank_lz <= 1'b0;
      r_sh_hex      <= 1'b0;
      r_sh_bright   <= '0;
    end else if (w_frame_end) begin
      r_sh_digits   <= i_digits_in;
      r_sh_dp       <= i_dp_in;
      r_sh_blank_lz <= i_blank_lz;
      r_sh_hex      <= i_hex_mode;
      r_sh_bright   <= i_brightness;
    end
  end

  // Anode is enabled for the first brightness*STEP cycles of each slot, so
  // the top code still leaves one STEP of dark time per slot.
  assign w_thresh = 32'(r_sh_bright) * 32'(c_STEP);
  assign w_pwm_en = (32'(r_pre) < w_thresh);

  // --------------------------------------------------------------------------
  // Leading-zero detection: digit i blanks when it and every more
  // significant nibble are zero. Digit 0 always shows.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_lz_lsd
        assign w_lz_blank[gi] = 1'b0;
      end else begin : g_lz_upper
        assign w_lz_blank[gi] = r_sh_blank_lz &&
                                (r_sh_digits[4*DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Current digit selection and next output values
  // --------------------------------------------------------------------------
  always_comb begin
    w_nib       = 4'h0;
    w_cur_dp    = 1'b0;
    w_cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == c_IDX_W'(i)) begin
        w_nib       = r_sh_digits[4*i +: 4];
        w_cur_dp    = r_sh_dp[i];
        w_cur_blank = w_lz_blank[i];
      end
    end
  end

  // Active-high glyph, bit 0 = segment a ... bit 6 = segment g
  always_comb begin
    w_glyph = 7'h40;
    case (w_nib)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = r_sh_hex ? 7'h77 : 7'h40;
      4'hB: w_glyph = r_sh_hex ? 7'h7C : 7'h40;
      4'hC: w_glyph = r_sh_hex ? 7'h39 : 7'h40;
      4'hD: w_glyph = r_sh_hex ? 7'h5E : 7'h40;
      4'hE: w_glyph = r_sh_hex ? 7'h79 : 7'h40;
      4'hF: w_glyph = r_sh_hex ? 7'h71 : 7'h40;
      default: w_glyph = 7'h40;
    endcase
  end

  // A blanked digit still lights its anode when its decimal point is
  // requested, showing only the point.
  assign w_on = w_pwm_en && (!w_cur_blank || w_cur_dp);

  always_comb begin
    w_seg_n_nxt = (w_on && !w_cur_blank) ? ~w_glyph : 7'h7F;
    w_dp_n_nxt  = !(w_on && w_cur_dp);
    w_dig_n_nxt = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_on && (r_idx == c_IDX_W'(i))) begin
        w_dig_n_nxt[i] = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs; async reset darkens the display immediately.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_seg_n      <= 7'h7F;
      o_dp_n       <= 1'b1;
      o_dig_n      <= '1;
      o_frame_sync <= 1'b0;
    end else begin
      o_seg_n      <= w_seg_n_nxt;
      o_dp_n       <= w_dp_n_nxt;
      o_dig_n      <= w_dig_n_nxt;
      o_frame_sync <= w_frame_end;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_n
// Description : Scoreboard bench for seg7_scan_n (DIGITS=3, SCAN_DIV=16,
//               PWM_BITS=2). A time-based reference model pushes the expected
//               output word for every clock edge; a monitor pops and compares
//               on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_n;

  localparam int D    = 3;
  localparam int S    = 16;
  localparam int P    = 2;
  localparam int STEP = S / (2 ** P);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [4*D-1:0] digits;
  logic [D-1:0]   dp;
  logic           blz;
  logic           hexm;
  logic [P-1:0]   bright;
  logic [6:0]     seg_n;
  logic           dp_n;
  logic [D-1:0]   dig_n;
  logic           fsync;

  seg7_scan_n #(.DIGITS(D), .SCAN_DIV(S), .PWM_BITS(P)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_digits_in  (digits),
    .i_dp_in      (dp),
    .i_blank_lz   (blz),
    .i_hex_mode   (hexm),
    .i_brightness (bright),
    .o_seg_n      (seg_n),
    .o_dp_n       (dp_n),
    .o_dig_n      (dig_n),
    .o_frame_sync (fsync)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]   seg;
    logic         dpn;
    logic [D-1:0] dig;
    logic         fs;
    logic         chk_seg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: cycles elapsed since reset release plus the
  // values latched at the most recent frame boundary.
  int             m_t = 0;
  logic [4*D-1:0] m_dig = '0;
  logic [D-1:0]   m_dp = '0;
  logic           m_blz = 1'b0;
  logic           m_hex = 1'b0;
  logic [P-1:0]   m_br = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Active-high a..g pattern for a displayed value
  function automatic logic [6:0] glyph(input logic [3:0] v, input logic hx);
    logic [6:0] g;
    case (v)
      4'd0: g = 7'h3F;  4'd1: g = 7'h06;  4'd2: g = 7'h5B;  4'd3: g = 7'h4F;
      4'd4: g = 7'h66;  4'd5: g = 7'h6D;  4'd6: g = 7'h7D;  4'd7: g = 7'h07;
      4'd8: g = 7'h7F;  4'd9: g = 7'h6F;
      4'd10: g = 7'h77; 4'd11: g = 7'h7C; 4'd12: g = 7'h39;
      4'd13: g = 7'h5E; 4'd14: g = 7'h79; default: g = 7'h71;
    endcase
    if (v > 4'd9 && !hx) g = 7'h40;
    return g;
  endfunction

  function automatic exp_t expect_at(input int pre, input int idx);
    exp_t       e;
    logic [3:0] nib;
    bit         blanked;
    bit         dpb;
    bit         on;
    nib     = 4'((m_dig >> (4 * idx)) & 12'hF);
    blanked = (idx > 0) && m_blz && ((m_dig >> (4 * idx)) == 0);
    dpb     = m_dp[idx];
    on      = (pre < int'(m_br) * STEP) && (!blanked || dpb);
    e.dig     = on ? ~(D'(1) << idx) : '1;
    e.seg     = blanked ? 7'h7F : ~glyph(nib, m_hex);
    e.dpn     = !(on && dpb);
    e.chk_seg = on;
    e.fs      = (pre == S - 1) && (idx == D - 1);
    return e;
  endfunction

  // Model: one expected word per rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst) begin
        e = '{seg: 7'h7F, dpn: 1'b1, dig: '1, fs: 1'b0, chk_seg: 1'b1};
        q.push_back(e);
        m_t = 0; m_dig = '0; m_dp = '0; m_blz = 0; m_hex = 0; m_br = '0;
      end else begin
        e = expect_at(m_t % S, (m_t / S) % D);
        q.push_back(e);
        if (e.fs) begin
          m_dig = digits; m_dp = dp; m_blz = blz; m_hex = hexm; m_br = bright;
        end
        m_t++;
      end
    end
  end

  // Monitor: compare on every falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        chk("queue_empty", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("dig_n", 32'(dig_n), 32'(e.dig));
        chk("frame_sync", 32'(fsync), 32'(e.fs));
        if (e.chk_seg) begin
          chk("seg_n", 32'(seg_n), 32'(e.seg));
          chk("dp_n", 32'(dp_n), 32'(e.dpn));
        end
      end
    end
  end

  // Count falling edges from release to the first frame_sync
  task automatic first_sync(input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (fsync && n == 0) n = i;
    end
    chk(name, 32'(n), 32'(D * S));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < D; i++)
      digits[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    dp     = D'($urandom);
    blz    = 1'($urandom);
    hexm   = 1'($urandom);
    bright = P'($urandom);
  endtask

  initial begin
    digits = 12'h123; dp = '0; blz = 0; hexm = 0; bright = 2'd3;
    cycles(3);
    rst = 0;
    first_sync("first_sync_after_reset");
    cycles(2 * D * S);
    // leading-zero blanking with dp on a blanked digit
    digits = 12'h007; blz = 1; dp = 3'b100;
    cycles(2 * D * S);
    // dash vs hex glyphs, no blanking
    digits = 12'h0AF; blz = 0; dp = '0; hexm = 0;
    cycles(2 * D * S);
    hexm = 1;
    cycles(2 * D * S);
    // brightness extremes
    bright = 2'd0;
    cycles(2 * D * S);
    bright = 2'd1;
    cycles(2 * D * S);
    // mid-frame input change
    bright = 2'd3; digits = 12'h111; hexm = 0;
    cycles(2 * D * S + 20);
    digits = 12'h222;
    cycles(2 * D * S);
    // async reset at cycle 8 of slot 1
    for (int i = 0; i < 100; i++) begin
      if ((m_t % S) == 8 && ((m_t / S) % D) == 1) break;
      @(negedge clk);
    end
    #2 rst = 1;
    #1;
    chk("async_rst_seg_n", 32'(seg_n), 32'h7F);
    chk("async_rst_dp_n", 32'(dp_n), 32'd1);
    chk("async_rst_dig_n", 32'(dig_n), 32'h7);
    chk("async_rst_fsync", 32'(fsync), 32'd0);
    cycles(3);
    rst = 0;
    first_sync("first_sync_after_rerelease");
    // randomized phase: occasional input changes at arbitrary points
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) rand_inputs();
    end
    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
